// File: rtl/alu_issue.sv
// alu_issue: two-stage issue/writeback front end for an external registered ALU.
// Stage S1 presents opcode and operands to the ALU; stage S2 observes the ALU
// result, drives the writeback port and commits it to the register file.
// Optional build macro ALU_ISSUE_BYPASS_EN: operand reads that hit the register
// being written back in S2 take alu_result directly instead of stalling.
module alu_issue #(
  parameter int NREGS = 32,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  output logic [4:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_value1,
  output logic [WIDTH-1:0] alu_value2,
  input  logic [WIDTH-1:0] alu_result,
  output logic             wb_valid,
  output logic [4:0]       wb_rd,
  output logic [WIDTH-1:0] wb_data,
  input  logic [4:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data,
  output logic [31:0]      retired
);

  logic [WIDTH-1:0] rf [NREGS];

  logic             s1_valid;
  logic [4:0]       s1_rd;
  logic             s2_valid;
  logic [4:0]       s2_rd;

  logic             s1_hit;
  logic             s2_match1;
  logic             s2_match2;
  logic             accept;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;

  // Hazard detection against the instructions currently in S1 and S2.
  always_comb begin
    s1_hit    = s1_valid && (s1_rd != 5'd0) && ((s1_rd == in_rs1) || (s1_rd == in_rs2));
    s2_match1 = s2_valid && (s2_rd != 5'd0) && (s2_rd == in_rs1);
    s2_match2 = s2_valid && (s2_rd != 5'd0) && (s2_rd == in_rs2);
`ifdef ALU_ISSUE_BYPASS_EN
    in_ready  = !s1_hit;
`else
    // The S2 result is only committed at the end of the cycle, so wait for it.
    in_ready  = !(s1_hit || s2_match1 || s2_match2);
`endif
    accept    = in_valid && in_ready;
  end

  // Operand read: x0 is hardwired to zero, optional write-through from S2.
  always_comb begin
    op1 = '0;
    op2 = '0;
    if ((in_rs1 != 5'd0) && (int'(in_rs1) < NREGS)) op1 = rf[in_rs1];
    if ((in_rs2 != 5'd0) && (int'(in_rs2) < NREGS)) op2 = rf[in_rs2];
`ifdef ALU_ISSUE_BYPASS_EN
    if (s2_match1) op1 = alu_result;
    if (s2_match2) op2 = alu_result;
`endif
  end

  // Debug read port sees committed state only.
  always_comb begin
    dbg_data = '0;
    if ((dbg_addr != 5'd0) && (int'(dbg_addr) < NREGS)) dbg_data = rf[dbg_addr];
  end

  // Writeback observation comes straight from S2 and the ALU output register.
  always_comb begin
    wb_valid = s2_valid;
    wb_rd    = s2_rd;
    wb_data  = alu_result;
  end

  // Pipeline registers; ALU inputs hold their last values when nothing issues.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1_rd      <= 5'd0;
      s2_valid   <= 1'b0;
      s2_rd      <= 5'd0;
      alu_opcode <= 5'd0;
      alu_value1 <= '0;
      alu_value2 <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_rd      <= in_rd;
        alu_opcode <= in_opcode;
        alu_value1 <= op1;
        alu_value2 <= op2;
      end
      s2_valid <= s1_valid;
      if (s1_valid) s2_rd <= s1_rd;
    end
  end

  // Register file commit at the end of the S2 cycle; rd=0 is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) rf[i] <= '0;
    end else if (s2_valid && (s2_rd != 5'd0) && (int'(s2_rd) < NREGS)) begin
      rf[s2_rd] <= alu_result;
    end
  end

  // Retire counter counts every writeback, including rd=0, and wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      retired <= 32'd0;
    end else if (s2_valid) begin
      retired <= retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: registered ALU model, program-order reference model,
// directed scenarios and randomized instruction streams.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0;
  logic [4:0]  in_rs1 = '0;
  logic [4:0]  in_rs2 = '0;
  logic [4:0]  alu_opcode;
  logic [63:0] alu_value1;
  logic [63:0] alu_value2;
  logic [63:0] alu_result = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic [4:0]  dbg_addr = '0;
  logic [63:0] dbg_data;
  logic [31:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  alu_issue #(.NREGS(32), .WIDTH(64)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .alu_opcode(alu_opcode), .alu_value1(alu_value1), .alu_value2(alu_value2),
    .alu_result(alu_result),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .retired(retired)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_NOT = 5'd8;

  function automatic logic [63:0] alu_fn(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b);
    case (op)
      5'd0: return a + b;
      5'd1: return a - b;
      5'd2: return a * b;
      5'd3: return (b == 64'd0) ? '1 : a / b;
      5'd4: return a ^ b;
      5'd5: return a & b;
      5'd6: return a | b;
      5'd7: return (b == 64'd0) ? a : a % b;
      5'd8: return ~a;
      default: return a + b + {59'd0, op};
    endcase
  endfunction

  // The external ALU: result registered one cycle after its inputs.
  always @(posedge clk) alu_result <= alu_fn(alu_opcode, alu_value1, alu_value2);

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: arch holds program-order values, comm the committed file,
  // fl the instructions accepted but not yet retired with their age in cycles.
  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] val;
    logic [1:0]  age;
  } fl_t;

  logic [63:0] arch [32];
  logic [63:0] comm [32];
  logic [31:0] m_retired;
  fl_t         fl [$];

  task automatic model_clear();
    for (int i = 0; i < 32; i++) begin
      arch[i] = '0;
      comm[i] = '0;
    end
    m_retired = '0;
    fl.delete();
  endtask

  // Compare DUT outputs with the model every cycle, then advance the model.
  always @(negedge clk) begin : cmp
    logic        hz, wv;
    logic [4:0]  wrd;
    logic [63:0] wdat, res;
    if (reset_n) begin
      hz = 1'b0; wv = 1'b0; wrd = '0; wdat = '0;
      foreach (fl[i]) begin
        if (fl[i].rd != 5'd0 && (fl[i].rd == in_rs1 || fl[i].rd == in_rs2)) begin
          if (fl[i].age == 2'd1) hz = 1'b1;
`ifndef ALU_ISSUE_BYPASS_EN
          if (fl[i].age == 2'd2) hz = 1'b1;
`endif
        end
        if (fl[i].age == 2'd2) begin
          wv = 1'b1; wrd = fl[i].rd; wdat = fl[i].val;
        end
      end
      chk("in_ready", 64'(in_ready), 64'(!hz));
      chk("wb_valid", 64'(wb_valid), 64'(wv));
      if (wv) begin
        chk("wb_rd", 64'(wb_rd), 64'(wrd));
        chk("wb_data", wb_data, wdat);
      end
      chk("retired", 64'(retired), 64'(m_retired));
      chk("dbg_data", dbg_data, comm[dbg_addr]);
      if (wv) begin
        if (wrd != 5'd0) comm[wrd] = wdat;
        m_retired = m_retired + 32'd1;
      end
      if (fl.size() > 0 && fl[0].age == 2'd2) void'(fl.pop_front());
      foreach (fl[i]) fl[i].age = fl[i].age + 2'd1;
      if (in_valid && !hz) begin
        res = alu_fn(in_opcode, arch[in_rs1], arch[in_rs2]);
        if (in_rd != 5'd0) arch[in_rd] = res;
        fl.push_back('{rd: in_rd, val: res, age: 2'd1});
      end
    end
  end

  // Present one instruction and hold it until accepted; returns stall cycles.
  task automatic issue(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, output int stalls);
    in_valid = 1'b1; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    stalls = 0;
    #1;
    while (!in_ready && stalls < 10) begin
      @(posedge clk); #1;
      stalls++;
    end
    if (!in_ready) begin
      n_checks++; n_errors++;
      $display("FAIL issue_timeout: in_ready stuck low for %0d cycles", stalls);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic start_reset();
    reset_n = 1'b0;
    model_clear();
  endtask

  int st;
  logic [31:0] r0;

  initial begin
    model_clear();
    start_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_wb_valid", 64'(wb_valid), 64'd0);
    reset_n = 1'b1;
    #1;
    chk("ready_after_reset", 64'(in_ready), 64'd1);
    chk("retired_after_reset", 64'(retired), 64'd0);

    // NOT x1 = ~x0
    issue(OP_NOT, 5'd1, 5'd0, 5'd0, st);
    @(posedge clk); #1;
    chk("not_wb_valid", 64'(wb_valid), 64'd1);
    chk("not_wb_data", wb_data, 64'hFFFF_FFFF_FFFF_FFFF);
    dbg_addr = 5'd1;
    @(posedge clk); #1;
    chk("not_dbg_x1", dbg_data, 64'hFFFF_FFFF_FFFF_FFFF);
    drain();

    // Back-to-back dependency: SUB x2 = x0 - x1
    issue(OP_NOT, 5'd1, 5'd0, 5'd0, st);
    issue(OP_SUB, 5'd2, 5'd0, 5'd1, st);
`ifdef ALU_ISSUE_BYPASS_EN
    chk("dep_stall_cycles", 64'(st), 64'd1);
`else
    chk("dep_stall_cycles", 64'(st), 64'd2);
`endif
    drain();
    dbg_addr = 5'd2; #1;
    chk("sub_dbg_x2", dbg_data, 64'd1);

    // Four independent ADDs on consecutive cycles
    r0 = retired;
    issue(OP_ADD, 5'd3, 5'd1, 5'd2, st); chk("add0_stall", 64'(st), 64'd0);
    issue(OP_ADD, 5'd4, 5'd2, 5'd2, st); chk("add1_stall", 64'(st), 64'd0);
    issue(OP_ADD, 5'd5, 5'd1, 5'd1, st); chk("add2_stall", 64'(st), 64'd0);
    issue(OP_ADD, 5'd6, 5'd2, 5'd0, st); chk("add3_stall", 64'(st), 64'd0);
    drain();
    chk("add_retired_delta", 64'(retired - r0), 64'd4);
    dbg_addr = 5'd3; #1; chk("add_x3", dbg_data, 64'd0);
    dbg_addr = 5'd4; #1; chk("add_x4", dbg_data, 64'd2);
    dbg_addr = 5'd5; #1; chk("add_x5", dbg_data, 64'hFFFF_FFFF_FFFF_FFFE);
    dbg_addr = 5'd6; #1; chk("add_x6", dbg_data, 64'd1);

    // Writeback to x0 is observed but not committed
    issue(OP_SUB, 5'd1, 5'd0, 5'd1, st);
    issue(OP_ADD, 5'd0, 5'd1, 5'd1, st);
    @(posedge clk); #1;
    chk("x0_wb_valid", 64'(wb_valid), 64'd1);
    chk("x0_wb_rd", 64'(wb_rd), 64'd0);
    chk("x0_wb_data", wb_data, 64'd2);
    drain();
    dbg_addr = 5'd0; #1;
    chk("x0_dbg", dbg_data, 64'd0);

    // Reset while an instruction sits in S1
    issue(OP_ADD, 5'd7, 5'd1, 5'd1, st);
    start_reset();
    #1;
    chk("reset_s1_wb_valid", 64'(wb_valid), 64'd0);
    @(posedge clk); #1;
    chk("reset_s1_wb_valid2", 64'(wb_valid), 64'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    drain();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i); #1;
      chk("reset_rf_zero", dbg_data, 64'd0);
    end
    chk("reset_retired_zero", 64'(retired), 64'd0);

    // Randomized stream with dense register reuse
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 9) < 7);
      in_opcode = 5'($urandom_range(0, 31));
      in_rd     = 5'($urandom_range(0, 7));
      in_rs1    = 5'($urandom_range(0, 7));
      in_rs2    = 5'($urandom_range(0, 7));
      dbg_addr  = 5'($urandom_range(0, 7));
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain();

    // Retire counter wrap
    force dut.retired = 32'hFFFF_FFFF;
    m_retired = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    release dut.retired;
    @(posedge clk); #1;
    chk("wrap_preload", 64'(retired), 64'hFFFF_FFFF);
    issue(OP_ADD, 5'd9, 5'd2, 5'd2, st);
    drain();
    chk("wrap_retired", 64'(retired), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
- REQ-001: Parameter NREGS, default 32, number of architectural registers; register 0 always reads zero.
- REQ-002: Parameter WIDTH, default 64, datapath width, which matches the downstream ALU.
- REQ-003: clk, input, 1, the single clock; all state is updated on its rising edge.
- REQ-004: reset_n, input, 1, asynchronous active-low reset.
- REQ-005: in_valid, input, 1, an instruction is presented.
- REQ-006: in_ready, output, 1, combinational; the instruction is accepted on the edge where in_valid and in_ready are both high.
- REQ-007: in_opcode, input, 5, ALU opcode: ADD=0, SUB=1, MUL=2, DIV=3, XOR=4, AND=5, OR=6, REM=7, NOT=8.
- REQ-008: in_rd / in_rs1 / in_rs2, input, 5 each, destination and source register indices.
- REQ-009: alu_opcode, output, 5; alu_value1 / alu_value2, output, WIDTH; all registered, driving the ALU inputs.
- REQ-010: alu_result, input, WIDTH, ALU output, registered one cycle after its inputs.
- REQ-011: wb_valid, output, 1; wb_rd, output, 5; wb_data, output, WIDTH; writeback observation port.
- REQ-012: dbg_addr, input, 5; dbg_data, output, WIDTH; combinational register-file read.
- REQ-013: retired, output, 32, count of retired instructions.

Function
- REQ-014: Pipeline: S1 holds operands on the ALU inputs; S2 holds the ALU result. At most one instruction occupies each stage, and the block accepts up to one instruction per cycle.
- REQ-015: On accept at edge E, s1_valid, s1_rd and the alu_* outputs load in_opcode, rf[rs1] and rf[rs2].
- REQ-016: At edge E+1, S1 moves to S2: s2_valid and s2_rd are loaded and the ALU captures its result.
- REQ-017: While s2_valid is high, the block drives wb_valid=1, wb_rd=s2_rd and wb_data=alu_result.
- REQ-018: rf[s2_rd] is written at the end of the S2 cycle, at edge E+2.
- REQ-019: A writeback with rd=0 drives wb_valid but does not modify the register file.
- REQ-020: When no instruction is accepted, s1_valid clears at the next edge and the alu_* outputs hold their last values.
- REQ-021: Hazard on S1: in_ready is low when s1_valid is high, s1_rd is nonzero, and s1_rd equals in_rs1 or in_rs2.
- REQ-022: Hazard on S2: operand reads whose index equals an active nonzero s2_rd are handled per REQ-029 and REQ-030.
- REQ-023: in_ready is high in every other case; the block has no other back-pressure.
- REQ-024: retired increments by 1 on each cycle with wb_valid high, including writebacks with rd=0, and wraps from 0xFFFFFFFF to 0.
- REQ-025: Opcodes 9-31 are passed through to the ALU unchanged and retire normally.

Reset
- REQ-026: Assertion of reset_n (low) asynchronously clears s1_valid, s2_valid, all register-file entries, alu_opcode, alu_value1, alu_value2, wb_rd and retired to 0.
- REQ-027: An instruction in flight during reset is discarded without writeback, and wb_valid is 0 throughout reset.
- REQ-028: in_ready is high in the first cycle after reset_n deasserts.

Configuration
- REQ-029: With macro ALU_ISSUE_BYPASS_EN defined, an operand read whose index equals the active nonzero s2_rd returns alu_result (write-through), so a dependent instruction stalls at most 1 cycle.
- REQ-030: Without ALU_ISSUE_BYPASS_EN, in_ready is also low on a match against the active nonzero s2_rd, so a back-to-back dependent instruction stalls 2 cycles.

Verification
- REQ-031: Reset, then NOT rd=1 rs1=0 -> wb_data=0xFFFFFFFFFFFFFFFF in the cycle after accept; dbg_addr=1 returns the same value from the following cycle.
- REQ-032: NOT x1, then SUB rd=2 rs1=0 rs2=1 back-to-back -> in_ready low for 1 cycle with bypass or 2 cycles without; x2=1.
- REQ-033: Four independent ADD instructions on consecutive cycles -> four consecutive wb_valid cycles; retired increases by 4.
- REQ-034: ADD rd=0 rs1=1 rs2=1 with x1=1 -> wb_valid=1 and wb_data=2, but dbg_addr=0 returns 0.
- REQ-035: reset_n pulsed low while an instruction is in S1 -> no writeback occurs and all registers and retired read 0.
- REQ-036: retired forced to 0xFFFFFFFF, then one retire -> retired=0.
